// File: rtl/alu_pkg.sv
// alu_pkg: ALU function codes shared with the ALU, plus the arbiter FSM state encoding
package alu_pkg;
    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant; a tie goes to the requester not granted last
import alu_pkg::*;

module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt,
    output logic       o_idx
);
    always_comb begin
        o_idx = (i_req == 2'b11) ? ~i_last : (i_req == 2'b10);
        o_gnt = (i_req == 2'b00) ? 2'b00 : (o_idx ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two requesters, waits the op latency, returns a buffered response
import alu_pkg::*;

module alu_arbiter #(
    parameter int unsigned ADD_CYCLES   = 2,
    parameter int unsigned LOGIC_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data1,
    input  logic [7:0] i_req0_data2,
    input  logic [2:0] i_req0_select,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data1,
    input  logic [7:0] i_req1_data2,
    input  logic [2:0] i_req1_select,
    output logic       o_req1_ready,
    output logic [7:0] o_alu_data1,
    output logic [7:0] o_alu_data2,
    output logic [2:0] o_alu_select,
    input  logic [7:0] i_alu_result,
    input  logic       i_alu_zero,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic       o_rsp_id,
    output logic [7:0] o_rsp_result,
    output logic       o_rsp_zero,
    output logic       o_rsp_err
);
    localparam logic [3:0] ADD_N   = 4'(ADD_CYCLES);
    localparam logic [3:0] LOGIC_N = 4'(LOGIC_CYCLES);
    state_t     r_state, w_next;
    logic       r_last, r_rsp_valid, r_rsp_id, r_rsp_zero, r_rsp_err;
    logic [3:0] r_cnt;
    logic [7:0] r_alu_d1, r_alu_d2, r_rsp_result;
    logic [2:0] r_alu_sel;
    logic [1:0] w_gnt;
    logic       w_idx, w_accept, w_done;
    logic [7:0] w_d1, w_d2;
    logic [2:0] w_sel;
    rr_arb2 u_arb (
        .i_req  ({i_req1_valid, i_req0_valid}),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );
    always_comb begin
        o_req0_ready = (r_state == IDLE) && w_gnt[0];
        o_req1_ready = (r_state == IDLE) && w_gnt[1];
        w_accept     = o_req0_ready || o_req1_ready;
        w_d1         = w_idx ? i_req1_data1 : i_req0_data1;
        w_d2         = w_idx ? i_req1_data2 : i_req0_data2;
        w_sel        = w_idx ? i_req1_select : i_req0_select;
        w_done       = (r_state == EXEC) && (r_cnt == 4'd1);
        w_next       = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? EXEC : IDLE;
            EXEC:    w_next = w_done ? RESP : EXEC;
            RESP:    w_next = i_rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    // Reserved selects spend one EXEC cycle with the error response already loaded, so
    // their response appears one cycle after accept like the fastest real op.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_cnt        <= 4'd0;
            r_alu_d1     <= 8'd0;
            r_alu_d2     <= 8'd0;
            r_alu_sel    <= ALU_FWD;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 8'd0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= (w_next == RESP);
            if (r_state == EXEC)
                r_cnt <= r_cnt - 4'd1;
            if (w_accept) begin
                r_last    <= w_idx;
                r_rsp_id  <= w_idx;
                r_rsp_err <= w_sel[2];
                r_cnt     <= w_sel[2] ? 4'd1 : (w_sel == ALU_ADD) ? ADD_N : LOGIC_N;
                if (w_sel[2]) begin
                    r_rsp_result <= 8'd0;
                    r_rsp_zero   <= 1'b0;
                end else begin
                    r_alu_d1  <= w_d1;
                    r_alu_d2  <= w_d2;
                    r_alu_sel <= w_sel;
                end
            end
            if (w_done && !r_rsp_err) begin
                r_rsp_result <= i_alu_result;
                r_rsp_zero   <= i_alu_zero;
            end
        end
    end
    always_comb begin
        o_alu_data1  = r_alu_d1;
        o_alu_data2  = r_alu_d2;
        o_alu_select = r_alu_sel;
        o_rsp_valid  = r_rsp_valid;
        o_rsp_id     = r_rsp_id;
        o_rsp_result = r_rsp_result;
        o_rsp_zero   = r_rsp_zero;
        o_rsp_err    = r_rsp_err;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests of alu_arbiter against a behavioural ALU with hand-computed expectations
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data1 = 8'd0, req0_data2 = 8'd0, req1_data1 = 8'd0, req1_data2 = 8'd0;
    logic [2:0] req0_select = 3'd0, req1_select = 3'd0;
    logic       req0_ready, req1_ready;
    logic [7:0] alu_data1, alu_data2, alu_result;
    logic [2:0] alu_select;
    logic       alu_zero;
    logic       rsp_valid, rsp_id, rsp_zero, rsp_err;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_result;
    logic [11:0] rsp_bus;
    logic [18:0] alu_bus;
    logic [1:0]  rdy;
    int n_checks = 0;
    int n_fail = 0;

    alu_arbiter #(.ADD_CYCLES(2), .LOGIC_CYCLES(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .i_req0_data1(req0_data1), .i_req0_data2(req0_data2),
        .i_req0_select(req0_select), .o_req0_ready(req0_ready),
        .i_req1_valid(req1_valid), .i_req1_data1(req1_data1), .i_req1_data2(req1_data2),
        .i_req1_select(req1_select), .o_req1_ready(req1_ready),
        .o_alu_data1(alu_data1), .o_alu_data2(alu_data2), .o_alu_select(alu_select),
        .i_alu_result(alu_result), .i_alu_zero(alu_zero),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero), .o_rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_select)
            3'b000:  alu_result = alu_data2;
            3'b001:  alu_result = alu_data1 + alu_data2;
            3'b010:  alu_result = alu_data1 & alu_data2;
            3'b011:  alu_result = alu_data1 | alu_data2;
            default: alu_result = 8'h00;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    assign rsp_bus = {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err};
    assign alu_bus = {alu_data1, alu_data2, alu_select};
    assign rdy     = {req1_ready, req0_ready};

    task automatic set_req0(input logic v, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        req0_valid = v; req0_select = s; req0_data1 = a; req0_data2 = b;
    endtask

    task automatic set_req1(input logic v, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        req1_valid = v; req1_select = s; req1_data1 = a; req1_data2 = b;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (rsp_bus !== 12'h000) begin n_fail++; $display("FAIL reset_rsp: got %h want %h", rsp_bus, 12'h000); end
        n_checks++; if (alu_bus !== 19'h0) begin n_fail++; $display("FAIL reset_alu: got %h want %h", alu_bus, 19'h0); end
        n_checks++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want %b", rdy, 2'b00); end
        rst = 1'b0;
    endtask

    task automatic test_add;
        set_req0(1'b1, 3'b001, 8'd5, 8'd3);
        #1;
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL add_ready: got %b want %b", rdy, 2'b01); end
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++; if (alu_bus !== {8'd5, 8'd3, 3'b001}) begin n_fail++; $display("FAIL add_alu: got %h want %h", alu_bus, {8'd5, 8'd3, 3'b001}); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_early1: got %b want 0", rsp_valid); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_early2: got %b want 0", rsp_valid); end
        @(negedge clk);
        n_checks++; if (rsp_bus !== {1'b1, 1'b0, 8'h08, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_rsp: got %h want %h", rsp_bus, {1'b1, 1'b0, 8'h08, 1'b0, 1'b0}); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_done: got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req0(1'b1, 3'b011, 8'h0F, 8'hF0);
        set_req1(1'b1, 3'b010, 8'hAA, 8'h55);
        for (int r = 0; r < 3; r++) begin
            #1;
            n_checks++; if (rdy !== ((r == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_ready%0d: got %b want %b", r, rdy, (r == 1) ? 2'b10 : 2'b01); end
            @(negedge clk);
            @(negedge clk);
            n_checks++; if (rsp_bus !== ((r == 1) ? {1'b1, 1'b1, 8'h00, 1'b1, 1'b0} : {1'b1, 1'b0, 8'hFF, 1'b0, 1'b0}))
                begin n_fail++; $display("FAIL rr_rsp%0d: got %h want %h", r, rsp_bus, (r == 1) ? {1'b1, 1'b1, 8'h00, 1'b1, 1'b0} : {1'b1, 1'b0, 8'hFF, 1'b0, 1'b0}); end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        set_req1(1'b1, 3'b000, 8'h11, 8'h7E);
        #1;
        n_checks++; if (rdy !== 2'b10) begin n_fail++; $display("FAIL fwd_ready: got %b want %b", rdy, 2'b10); end
        @(negedge clk);
        req1_valid = 1'b0;
        set_req0(1'b1, 3'b000, 8'h00, 8'h01);
        #1;
        n_checks++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL fwd_exec_ready: got %b want %b", rdy, 2'b00); end
        n_checks++; if (alu_bus !== {8'h11, 8'h7E, 3'b000}) begin n_fail++; $display("FAIL fwd_alu: got %h want %h", alu_bus, {8'h11, 8'h7E, 3'b000}); end
        @(negedge clk);
        n_checks++; if (rsp_bus !== {1'b1, 1'b1, 8'h7E, 1'b0, 1'b0}) begin n_fail++; $display("FAIL fwd_rsp: got %h want %h", rsp_bus, {1'b1, 1'b1, 8'h7E, 1'b0, 1'b0}); end
        n_checks++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL fwd_resp_ready: got %b want %b", rdy, 2'b00); end
        @(negedge clk);
        #1;
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL b2b_ready: got %b want %b", rdy, 2'b01); end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_bus !== {1'b1, 1'b0, 8'h01, 1'b0, 1'b0}) begin n_fail++; $display("FAIL b2b_rsp: got %h want %h", rsp_bus, {1'b1, 1'b0, 8'h01, 1'b0, 1'b0}); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        set_req0(1'b1, 3'b010, 8'h3C, 8'h0F);
        #1;
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL bp_ready: got %b want %b", rdy, 2'b01); end
        @(negedge clk);
        req0_valid = 1'b0;
        set_req1(1'b1, 3'b000, 8'h00, 8'h99);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++; if (rsp_bus !== {1'b1, 1'b0, 8'h0C, 1'b0, 1'b0}) begin n_fail++; $display("FAIL bp_rsp%0d: got %h want %h", i, rsp_bus, {1'b1, 1'b0, 8'h0C, 1'b0, 1'b0}); end
            n_checks++; if (alu_bus !== {8'h3C, 8'h0F, 3'b010}) begin n_fail++; $display("FAIL bp_alu%0d: got %h want %h", i, alu_bus, {8'h3C, 8'h0F, 3'b010}); end
            n_checks++; if (rdy !== 2'b00) begin n_fail++; $display("FAIL bp_ready%0d: got %b want %b", i, rdy, 2'b00); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
        n_checks++; if (rdy !== 2'b10) begin n_fail++; $display("FAIL bp_idle_ready: got %b want %b", rdy, 2'b10); end
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reserved;
        set_req0(1'b1, 3'b101, 8'h12, 8'h34);
        #1;
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL err_ready: got %b want %b", rdy, 2'b01); end
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b want 0", rsp_valid); end
        n_checks++; if (alu_bus !== {8'h3C, 8'h0F, 3'b010}) begin n_fail++; $display("FAIL err_alu: got %h want %h", alu_bus, {8'h3C, 8'h0F, 3'b010}); end
        @(negedge clk);
        n_checks++; if (rsp_bus !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin n_fail++; $display("FAIL err_rsp: got %h want %h", rsp_bus, {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}); end
        n_checks++; if (alu_bus !== {8'h3C, 8'h0F, 3'b010}) begin n_fail++; $display("FAIL err_alu_hold: got %h want %h", alu_bus, {8'h3C, 8'h0F, 3'b010}); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL err_done: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid_exec;
        set_req0(1'b1, 3'b001, 8'h40, 8'h02);
        #1;
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL rme_ready: got %b want %b", rdy, 2'b01); end
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++; if (alu_bus !== {8'h40, 8'h02, 3'b001}) begin n_fail++; $display("FAIL rme_alu: got %h want %h", alu_bus, {8'h40, 8'h02, 3'b001}); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (rsp_bus !== 12'h000) begin n_fail++; $display("FAIL rme_rsp: got %h want %h", rsp_bus, 12'h000); end
        n_checks++; if (alu_bus !== 19'h0) begin n_fail++; $display("FAIL rme_alu_rst: got %h want %h", alu_bus, 19'h0); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rme_no_rsp%0d: got %b want 0", i, rsp_valid); end
        end
        set_req0(1'b1, 3'b000, 8'h00, 8'h01);
        set_req1(1'b1, 3'b000, 8'h00, 8'h02);
        #1;
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL rme_tie: got %b want %b", rdy, 2'b01); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_reserved();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
